// File: rtl/core_pkg.sv
// core_pkg: shared store-buffer types, default sizing and size normalisation
package core_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} mem_size_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    mem_size_t   size;
    logic        valid;
  } sb_entry_t;
  typedef enum logic {SB_IDLE, SB_REQ} sb_state_t;
  localparam int SB_SIZE_DEFAULT = 4;
  // The illegal encoding 11 is stored as a word access
  function automatic mem_size_t to_size(input logic [1:0] s);
    return s == 2'b11 ? SZ_WORD : mem_size_t'(s);
  endfunction
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: youngest valid word-address match, scanning oldest to youngest from head with wrap
module sb_fwd_match import core_pkg::*; #(
  parameter int SB_SIZE = SB_SIZE_DEFAULT
) (
  input  logic [SB_SIZE-1:0]         i_vld,
  input  logic [SB_SIZE-1:0][29:0]   i_waddr,
  input  logic [$clog2(SB_SIZE)-1:0] i_head,
  input  logic [29:0]                i_ld_waddr,
  output logic                       o_match,
  output logic [$clog2(SB_SIZE)-1:0] o_idx
);
  localparam int PTR_W = $clog2(SB_SIZE);
  // Later (younger) matches overwrite earlier ones, so the last hit wins
  always_comb begin
    o_match = 1'b0;
    o_idx = i_head;
    for (int k = 0; k < SB_SIZE; k++)
      if (i_vld[i_head + PTR_W'(k)] && i_waddr[i_head + PTR_W'(k)] == i_ld_waddr) begin
        o_match = 1'b1;
        o_idx = i_head + PTR_W'(k);
      end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: post-commit FIFO store buffer with D-cache drain FSM and load probe.
// Define STORE_BUFFER_FWD_EN to forward aligned word matches instead of blocking every match.
module store_buffer import core_pkg::*; #(
  parameter int SB_SIZE = SB_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_push,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_size,
  output logic        out_full,
  output logic        out_empty,
  output logic        out_mem_req,
  output logic [31:0] out_mem_addr,
  output logic [31:0] out_mem_data,
  output logic [1:0]  out_mem_size,
  input  logic        in_mem_ack,
  input  logic        in_ld_valid,
  input  logic [31:0] in_ld_addr,
  output logic        out_fwd_hit,
  output logic [31:0] out_fwd_data,
  output logic        out_ld_block
);
  localparam int PTR_W = $clog2(SB_SIZE);
  localparam int CNT_W = $clog2(SB_SIZE + 1);
  sb_entry_t              r_ent [SB_SIZE];
  logic [PTR_W-1:0]       r_head, r_tail;
  logic [CNT_W-1:0]       r_count;
  sb_state_t              r_state, w_state_nxt;
  logic                   w_push, w_pop, w_match;
  logic [PTR_W-1:0]       w_idx;
  logic [SB_SIZE-1:0]     w_vld;
  logic [SB_SIZE-1:0][29:0] w_waddr;
  assign out_full = r_count == CNT_W'(SB_SIZE);
  assign out_empty = r_count == '0;
  assign w_push = in_push && !out_full;
  assign w_pop = r_state == SB_REQ && in_mem_ack;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = r_state == SB_IDLE ? (out_empty ? SB_IDLE : SB_REQ) : (in_mem_ack ? SB_IDLE : SB_REQ);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_state <= SB_IDLE;
      for (int i = 0; i < SB_SIZE; i++) r_ent[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push) begin
        r_ent[r_tail] <= '{addr: in_addr, data: in_data, size: to_size(in_size), valid: 1'b1};
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_ent[r_head].valid <= 1'b0;
        r_head <= r_head + PTR_W'(1);
      end
    end
  end
  assign out_mem_req = r_state == SB_REQ;
  assign out_mem_addr = out_mem_req ? r_ent[r_head].addr : '0;
  assign out_mem_data = out_mem_req ? r_ent[r_head].data : '0;
  assign out_mem_size = out_mem_req ? r_ent[r_head].size : SZ_BYTE;
  always_comb
    for (int i = 0; i < SB_SIZE; i++) begin
      w_vld[i] = r_ent[i].valid;
      w_waddr[i] = r_ent[i].addr[31:2];
    end
  sb_fwd_match #(.SB_SIZE(SB_SIZE)) u_match (
    .i_vld(w_vld),
    .i_waddr(w_waddr),
    .i_head(r_head),
    .i_ld_waddr(in_ld_addr[31:2]),
    .o_match(w_match),
    .o_idx(w_idx)
  );
`ifdef STORE_BUFFER_FWD_EN
  sb_entry_t w_hit_ent;
  logic      w_ok;
  assign w_hit_ent = r_ent[w_idx];
  assign w_ok = in_ld_valid && w_match && w_hit_ent.size == SZ_WORD && w_hit_ent.addr[1:0] == 2'b00 && in_ld_addr[1:0] == 2'b00;
  assign out_fwd_hit = w_ok;
  assign out_fwd_data = w_ok ? w_hit_ent.data : '0;
  assign out_ld_block = in_ld_valid && w_match && !w_ok;
`else
  logic w_unused;
  assign w_unused = &{1'b0, in_ld_addr[1:0], w_idx};
  assign out_fwd_hit = 1'b0;
  assign out_fwd_data = '0;
  assign out_ld_block = in_ld_valid && w_match;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed plus randomized checks of store_buffer against a queue-based reference model
module tb_store_buffer;
  logic clk = 0, reset = 1, in_push = 0, in_mem_ack = 0, in_ld_valid = 0;
  logic [31:0] in_addr = 0, in_data = 0, in_ld_addr = 0;
  logic [1:0] in_size = 0;
  logic out_full, out_empty, out_mem_req, out_fwd_hit, out_ld_block;
  logic [31:0] out_mem_addr, out_mem_data, out_fwd_data;
  logic [1:0] out_mem_size;
  always #5 clk = ~clk;
  store_buffer dut (
    .clk(clk), .reset(reset), .in_push(in_push), .in_addr(in_addr), .in_data(in_data),
    .in_size(in_size), .out_full(out_full), .out_empty(out_empty), .out_mem_req(out_mem_req),
    .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data), .out_mem_size(out_mem_size),
    .in_mem_ack(in_mem_ack), .in_ld_valid(in_ld_valid), .in_ld_addr(in_ld_addr),
    .out_fwd_hit(out_fwd_hit), .out_fwd_data(out_fwd_data), .out_ld_block(out_ld_block)
  );
  typedef struct {logic [31:0] a; logic [31:0] d; logic [1:0] s;} st_t;
  st_t q[$];
  bit m_req = 0, en_cmp = 0;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void probe(output logic h, output logic b, output logic [31:0] d);
    h = 0; b = 0; d = 0;
    if (in_ld_valid)
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].a[31:2] == in_ld_addr[31:2]) begin
`ifdef STORE_BUFFER_FWD_EN
          if (q[i].s == 2'b10 && q[i].a[1:0] == 2'b00 && in_ld_addr[1:0] == 2'b00) begin h = 1; d = q[i].d; end
          else b = 1;
`else
          b = 1;
`endif
          break;
        end
  endfunction
  always @(posedge clk) begin
    bit full, pop, nreq;
    if (reset) begin
      q.delete();
      m_req = 0;
    end else begin
      full = q.size() == 4;
      pop = m_req && in_mem_ack;
      nreq = m_req ? !in_mem_ack : q.size() != 0;
      if (pop) void'(q.pop_front());
      if (in_push && !full) q.push_back('{in_addr, in_data, in_size == 2'b11 ? 2'b10 : in_size});
      m_req = nreq;
    end
  end
  always @(negedge clk) begin
    logic eh, eb;
    logic [31:0] ed;
    if (en_cmp) begin
      probe(eh, eb, ed);
      chk("m_full", out_full, q.size() == 4);
      chk("m_empty", out_empty, q.size() == 0);
      chk("m_req", out_mem_req, m_req);
      chk("m_addr", out_mem_addr, m_req && q.size() > 0 ? q[0].a : 0);
      chk("m_data", out_mem_data, m_req && q.size() > 0 ? q[0].d : 0);
      chk("m_size", out_mem_size, m_req && q.size() > 0 ? q[0].s : 0);
      chk("m_hit", out_fwd_hit, eh);
      chk("m_fdata", out_fwd_data, ed);
      chk("m_block", out_ld_block, eb);
    end
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    in_push = 1; in_addr = a; in_data = d; in_size = s;
    step();
    in_push = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask
  task automatic wait_req();
    int n = 0;
    while (!out_mem_req && n < 10) begin step(); n++; end
    chk("req_wait", out_mem_req, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    step(); step();
    reset = 0;
    en_cmp = 1;
    #1;
    chk("rst_empty", out_empty, 1);
    chk("rst_req", out_mem_req, 0);
    chk("rst_full", out_full, 0);
    chk("rst_block", out_ld_block, 0);
    push(32'h100, 32'hDEADBEEF, 2'b10);
    #1 chk("t1_req_n1", out_mem_req, 0);
    step();
    chk("t1_req_n2", out_mem_req, 1);
    chk("t1_addr", out_mem_addr, 32'h100);
    chk("t1_data", out_mem_data, 32'hDEADBEEF);
    chk("t1_size", out_mem_size, 2'b10);
    in_mem_ack = 1;
    step();
    in_mem_ack = 0;
    #1 chk("t1_empty", out_empty, 1);
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h10 * (i + 1), i + 1, 2'b10);
    #1 chk("t2_full", out_full, 1);
    push(32'h50, 5, 2'b10);
    for (int i = 0; i < 4; i++) begin
      wait_req();
      chk("t2_order_a", out_mem_addr, 32'h10 * (i + 1));
      chk("t2_order_d", out_mem_data, i + 1);
      in_mem_ack = 1;
      step();
      in_mem_ack = 0;
    end
    #1 chk("t2_empty", out_empty, 1);
    step();
    chk("t2_drop", out_mem_req, 0);
    do_reset();
    push(32'h200, 32'h1111, 2'b10);
    push(32'h200, 32'h2222, 2'b10);
    in_ld_valid = 1; in_ld_addr = 32'h200;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    chk("t3_hit", out_fwd_hit, 1);
    chk("t3_data", out_fwd_data, 32'h2222);
    chk("t3_block", out_ld_block, 0);
`else
    chk("t3_hit", out_fwd_hit, 0);
    chk("t3_data", out_fwd_data, 0);
    chk("t3_block", out_ld_block, 1);
`endif
    step();
    in_ld_valid = 0;
    do_reset();
    push(32'h303, 32'hAB, 2'b00);
    in_ld_valid = 1; in_ld_addr = 32'h300;
    #1;
    chk("t4_block", out_ld_block, 1);
    chk("t4_hit", out_fwd_hit, 0);
    step();
    in_ld_valid = 0;
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h10 * (i + 1), i + 1, 2'b10);
    wait_req();
    in_push = 1; in_addr = 32'h60; in_data = 6; in_size = 2'b10; in_mem_ack = 1;
    step();
    in_push = 0; in_mem_ack = 0;
    #1 chk("t5_cnt3", out_full, 0);
    push(32'h70, 7, 2'b10);
    #1 chk("t5_cnt4", out_full, 1);
    wait_req();
    chk("t5_head", out_mem_addr, 32'h20);
    do_reset();
    for (int i = 0; i < 3; i++) push(32'h10 * (i + 1), i + 1, 2'b10);
    wait_req();
    reset = 1;
    step();
    in_ld_valid = 1; in_ld_addr = 32'h10;
    #1;
    chk("t6_req", out_mem_req, 0);
    chk("t6_empty", out_empty, 1);
    chk("t6_block", out_ld_block, 0);
    chk("t6_hit", out_fwd_hit, 0);
    reset = 0;
    in_ld_valid = 0;
    step();
    for (int c = 0; c < 3000; c++) begin
      reset = $urandom_range(0, 99) == 0;
      in_push = $urandom_range(0, 1);
      in_addr = 32'h400 + ($urandom_range(0, 3) << 2) + ($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0);
      in_data = $urandom;
      in_size = 2'($urandom_range(0, 3));
      in_mem_ack = $urandom_range(0, 2) == 0;
      in_ld_valid = $urandom_range(0, 1);
      in_ld_addr = 32'h400 + ($urandom_range(0, 4) << 2) + ($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0);
      step();
    end
    reset = 0; in_push = 0; in_mem_ack = 0; in_ld_valid = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Post-commit store buffer, directly downstream of the reorder buffer's commit port.
- The ROB retires a store and pushes it here. The buffer holds committed stores in FIFO order and drains them one at a time to the data cache over a req/ack handshake.
- Younger loads probe it in parallel with the cache. Matching stores are either forwarded or the load is blocked.
- Committed stores are architectural: never flushed, only cleared by reset.

Parameters:
- SB_SIZE, 4, number of entries (power of two, 2..16)
- CNT_W, $clog2(SB_SIZE+1), occupancy counter width (derived, not overridden)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_push  in  1  ROB commits a store this cycle
- in_addr  in  32  store byte address
- in_data  in  32  store data, right-aligned
- in_size  in  2  00 byte, 01 half, 10 word (11 illegal, treated as word)
- out_full  out  1  no free entry; ROB must stall store commit
- out_empty  out  1  no valid entry (fence/exception drain indication)
- out_mem_req  out  1  drain request to D-cache
- out_mem_addr  out  32  head address
- out_mem_data  out  32  head data
- out_mem_size  out  2  head size
- in_mem_ack  in  1  cache accepted the request this cycle
- in_ld_valid  in  1  load probe valid
- in_ld_addr  in  32  load byte address
- out_fwd_hit  out  1  forwarded data valid
- out_fwd_data  out  32  forwarded word
- out_ld_block  out  1  load must replay (partial overlap)

Behaviour:
- Storage: circular FIFO. head, tail are $clog2(SB_SIZE) bits and wrap modulo SB_SIZE. count is CNT_W bits.
- Reset: head = tail = count = 0, all valid bits 0, FSM in IDLE. All outputs 0 except out_empty = 1.
- out_full = (count == SB_SIZE), combinational. out_empty = (count == 0), combinational.
- Push: accepted when in_push && !out_full. Writes entry[tail], sets its valid bit, tail++. A push asserted while full is dropped; the ROB must not do this.
- Full with pop in the same cycle: push is still refused, because out_full is sampled before the pop.
- Drain FSM, two states:
  - IDLE: if count != 0, go to REQ.
  - REQ: out_mem_req = 1, with address/data/size taken from entry[head] and held stable. On in_mem_ack: clear valid[head], head++, return to IDLE.
- Latency:
  - A store pushed into an empty buffer in cycle N gives out_mem_req in cycle N+2 (N+1 register update, N+1 IDLE→REQ, N+2 REQ).
  - Back-to-back drains have a minimum 2-cycle spacing.
- out_mem_req is a registered decode of the state. It never drops without an ack except on reset.
- Push and ack in the same cycle: count is unchanged, and both pointers advance.
- Reset while in REQ: request dropped immediately, contents discarded.
- Load probe (combinational, same cycle as in_ld_valid):
  - Compare in_ld_addr[31:2] against every valid entry's addr[31:2].
  - Youngest match is found by scanning from tail-1 back to head with wrap.
  - Youngest match has size word and addr[1:0] = 0, and in_ld_addr[1:0] = 0: out_fwd_hit = 1, out_fwd_data = entry data.
  - Youngest match is any other size or alignment: out_ld_block = 1, out_fwd_hit = 0.
  - No match, or in_ld_valid = 0: both outputs 0, and out_fwd_data = 0.
- Entry being drained (REQ) remains visible to probes until its ack cycle ends.
- An entry pushed in cycle N is visible to probes from cycle N+1.

Optional Feature:
- Macro: STORE_BUFFER_FWD_EN.
- Defined: forwarding exactly as above.
- Undefined: out_fwd_hit and out_fwd_data are tied 0, and any word-address match with a valid entry asserts out_ld_block. The load replays until the store drains.

Decomposition:
- Shared package core_pkg holds:
  - typedef mem_size_t (2-bit enum SZ_BYTE, SZ_HALF, SZ_WORD)
  - typedef sb_entry_t (addr, data, size, valid)
  - localparam SB_SIZE_DEFAULT = 4
- Optional sub-module sb_fwd_match: combinational youngest-match priority scan over the entry array and head/tail. Keeps the wrap-aware priority logic separately testable.

Test Plan:
- Reset, push one word store addr 0x100 data 0xDEADBEEF → out_mem_req in cycle 2 after push with addr 0x100, data 0xDEADBEEF, size 10. Ack it → out_empty = 1 next cycle.
- Push 4 stores with ack held low → out_full = 1, and a 5th push is dropped. Ack 4 times → drain order matches push order; tail and head wrap to 0.
- Probe 0x200 with two word stores to 0x200 (data 0x1111 then 0x2222) pending → out_fwd_hit = 1, out_fwd_data = 0x2222.
- Byte store to 0x303 pending, load probe 0x300 → out_ld_block = 1, out_fwd_hit = 0.
- Full buffer, push and ack in the same cycle → push refused, count drops to 3. Next cycle push accepted → count = 4.
- Assert reset while out_mem_req = 1 with 3 entries → next cycle out_mem_req = 0, out_empty = 1, and probes return no match.
